uart_serdes: RTL and testbench

Serial engine directly below the 6850-style ACIA register block: serializes bytes the ACIA writes and deserializes 8N1 frames from the `rx` pin. It exposes the single-cycle `transmit`/`received` handshake with busy and error flags that the ACIA's TXE/RXF/status logic consumes. Fixed 8 data bits, no parity, 1 stop bit, LSB first, 16x oversampling.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tick_gen.sv | 26 ++
 rtl/uart_serdes.sv | 199 +++++++++++++++++++
 tb/tb_uart_serdes.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared RX/TX state encodings, frame constants and the 2-of-3 sample vote for uart_serdes.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned PHASE_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase restartable.
module uart_tick_gen #(
  parameter int unsigned DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Tick is registered one count early so the consumer sees it exactly DIV clocks after restart.
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(DIV - 2));
      cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_serdes.sv
// 8N1 UART serializer/deserializer with 16x oversampling and independent RX/TX engines.
// Build option: UART_RX_FILTER_EN selects 2-of-3 majority RX sampling at ticks 7/8/9.
module uart_serdes
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SYS_CLK_FREQ = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int unsigned DIV = SYS_CLK_FREQ / (OVERSAMPLE * BAUD_RATE);

  logic rx_meta, rxs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_next;
  logic                 rx_tick, rx_restart_c, rx_decide_c, rx_sample_c;
  logic                 rx_good_c, rx_bad_c, rx_shift_en_c;
  logic [PHASE_W-1:0]   rx_phase, rx_phase_inc_c;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 samp_mid;
`ifdef UART_RX_FILTER_EN
  logic                 samp_early;
`endif

  uart_tick_gen #(.DIV(DIV)) u_rx_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (rx_restart_c),
    .tick    (rx_tick)
  );

  // Phase 0 is the bit boundary; every bit is decided at phase MID_TICK+1 in both builds.
  assign rx_restart_c   = (rx_state == RX_IDLE) && !rxs;
  assign rx_phase_inc_c = rx_phase + PHASE_W'(1);
  assign rx_decide_c    = rx_tick && (rx_phase_inc_c == PHASE_W'(MID_TICK + 1));
`ifdef UART_RX_FILTER_EN
  assign rx_sample_c    = maj3(samp_early, samp_mid, rxs);
`else
  assign rx_sample_c    = samp_mid;
`endif

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:    if (!rxs) rx_next = RX_START;
      RX_START:   if (rx_decide_c) rx_next = rx_sample_c ? RX_IDLE : RX_DATA;
      RX_DATA:    if (rx_decide_c && (rx_bit == BIT_W'(DATA_BITS - 1))) rx_next = RX_STOP;
      RX_STOP:    if (rx_decide_c) rx_next = rx_sample_c ? RX_IDLE : RX_RECOVER;
      RX_RECOVER: if (rxs) rx_next = RX_IDLE;
      default:    rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_good_c     = 1'b0;
    rx_bad_c      = 1'b0;
    rx_shift_en_c = 1'b0;
    if (rx_decide_c) begin
      if (rx_state == RX_DATA) rx_shift_en_c = 1'b1;
      if (rx_state == RX_STOP) begin
        rx_good_c = rx_sample_c;
        rx_bad_c  = !rx_sample_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_phase     <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      samp_mid     <= 1'b1;
`ifdef UART_RX_FILTER_EN
      samp_early   <= 1'b1;
`endif
      rx_byte      <= '0;
      received     <= 1'b0;
      recv_error   <= 1'b0;
      is_receiving <= 1'b0;
    end else begin
      received     <= rx_good_c;
      recv_error   <= rx_bad_c;
      is_receiving <= (rx_next != RX_IDLE);
      if (rx_state == RX_IDLE) begin
        rx_phase <= '0;
        rx_bit   <= '0;
      end else if (rx_tick) begin
        rx_phase <= rx_phase_inc_c;
      end
      if (rx_tick && (rx_phase_inc_c == PHASE_W'(MID_TICK))) samp_mid <= rxs;
`ifdef UART_RX_FILTER_EN
      if (rx_tick && (rx_phase_inc_c == PHASE_W'(MID_TICK - 1))) samp_early <= rxs;
`endif
      if (rx_shift_en_c) begin
        rx_shift <= {rx_sample_c, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BIT_W'(1);
      end
      if (rx_good_c) rx_byte <= rx_shift;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic                 tx_tick, tx_start_c, tx_bit_end_c, tx_line_c;
  logic [PHASE_W-1:0]   tx_phase, tx_phase_n_c;
  logic [BIT_W-1:0]     tx_bit, tx_bit_n_c;
  logic [DATA_BITS-1:0] tx_data, tx_data_n_c;

  uart_tick_gen #(.DIV(DIV)) u_tx_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (tx_start_c),
    .tick    (tx_tick)
  );

  assign tx_start_c   = (tx_state == TX_IDLE) && transmit;
  assign tx_bit_end_c = tx_tick && (tx_phase == PHASE_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (transmit) tx_next = TX_START;
      TX_START: if (tx_bit_end_c) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end_c && (tx_bit == BIT_W'(DATA_BITS - 1))) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end_c) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Line level is computed from the upcoming state so tx changes on the same edge as the FSM.
  always_comb begin
    tx_phase_n_c = tx_phase;
    tx_bit_n_c   = tx_bit;
    tx_data_n_c  = tx_data;
    if (tx_start_c) begin
      tx_phase_n_c = '0;
      tx_bit_n_c   = '0;
      tx_data_n_c  = tx_byte;
    end else if ((tx_state != TX_IDLE) && tx_tick) begin
      tx_phase_n_c = tx_phase + PHASE_W'(1);
      if ((tx_state == TX_DATA) && tx_bit_end_c) tx_bit_n_c = tx_bit + BIT_W'(1);
    end
    unique case (tx_next)
      TX_START: tx_line_c = 1'b0;
      TX_DATA:  tx_line_c = tx_data_n_c[tx_bit_n_c];
      default:  tx_line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_phase        <= '0;
      tx_bit          <= '0;
      tx_data         <= '0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
    end else begin
      tx_phase        <= tx_phase_n_c;
      tx_bit          <= tx_bit_n_c;
      tx_data         <= tx_data_n_c;
      tx              <= tx_line_c;
      is_transmitting <= (tx_next != TX_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// Scoreboard bench for uart_serdes: expected RX events and TX bytes are queued at stimulus time
// and consumed by independent line/handshake monitors.
module tb_uart_serdes;

  localparam int unsigned BIT_CLKS   = 1248;
  localparam int unsigned HALF_BIT   = 624;
  localparam int unsigned FRAME_CLKS = 12480;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx, received, is_receiving, is_transmitting, recv_error;
  logic [7:0] rx_byte;

  uart_serdes dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .tx              (tx),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .recv_error      (recv_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_evt_t;

  int         checks = 0;
  int         errors = 0;
  int         rx_events = 0;
  int         tx_frames = 0;
  int         n_rx = 0;
  rx_evt_t    rx_exp[$];
  logic [7:0] tx_exp[$];
  rx_evt_t    rx_got;
  logic [7:0] tx_want;
  logic       tx_mon_active = 1'b0;
  int         tx_mon_cnt = 0;
  logic [9:0] tx_mon_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RX handshake monitor
  always @(negedge clk) begin
    if (received || recv_error) begin
      rx_events++;
      if (rx_exp.size() == 0) begin
        check("rx_unexpected_pulse", {30'b0, received, recv_error}, 32'd0);
      end else begin
        rx_got = rx_exp.pop_front();
        check("rx_kind", 32'(recv_error), 32'(rx_got.err));
        if (!rx_got.err) check("rx_data", 32'(rx_byte), 32'(rx_got.data));
        else             check("rx_no_good_on_error", 32'(received), 32'd0);
      end
    end
  end

  // TX line monitor: samples mid-bit and measures the busy window
  always @(negedge clk) begin
    if (!rst) begin
      tx_mon_active = 1'b0;
    end else if (!tx_mon_active) begin
      if (is_transmitting) begin
        tx_mon_active = 1'b1;
        tx_mon_cnt    = 0;
        tx_mon_bits   = '0;
      end
    end else begin
      tx_mon_cnt++;
      if (!is_transmitting) begin
        tx_mon_active = 1'b0;
        tx_frames++;
        check("tx_busy_clocks", 32'(tx_mon_cnt), 32'(FRAME_CLKS));
        check("tx_start_bit", 32'(tx_mon_bits[0]), 32'd0);
        check("tx_stop_bit", 32'(tx_mon_bits[9]), 32'd1);
        if (tx_exp.size() == 0) begin
          check("tx_unexpected_frame", 32'(tx_exp.size()), 32'd1);
        end else begin
          tx_want = tx_exp.pop_front();
          check("tx_data", 32'(tx_mon_bits[8:1]), 32'(tx_want));
        end
      end else if ((tx_mon_cnt % BIT_CLKS) == HALF_BIT && (tx_mon_cnt / BIT_CLKS) < 10) begin
        tx_mon_bits[tx_mon_cnt / BIT_CLKS] = tx;
      end
    end
  end

  task automatic do_transmit(input logic [7:0] b);
    @(negedge clk);
    transmit = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    transmit = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      @(negedge clk);
      rx = f[c / BIT_CLKS] ^ (c == glitch_at);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_events < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_event_count", 32'(rx_events), 32'(n));
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_frame_count", 32'(tx_frames), 32'(n));
  endtask

  initial begin
    // reset with rx toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    rx = 1'b1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    check("rst_received", 32'(received), 32'd0);
    check("rst_recv_error", 32'(recv_error), 32'd0);
    check("rst_is_receiving", 32'(is_receiving), 32'd0);
    check("rst_is_transmitting", 32'(is_transmitting), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_rx", 32'(is_receiving), 32'd0);

    // TX 0x55 with an ignored mid-frame transmit of 0xFF
    tx_exp.push_back(8'h55);
    do_transmit(8'h55);
    check("tx_busy_rise", 32'(is_transmitting), 32'd1);
    check("tx_fall_first_edge", 32'(tx), 32'd0);
    repeat (3000) @(negedge clk);
    do_transmit(8'hFF);
    wait_tx(1, FRAME_CLKS);

    // RX 0xA5
    repeat (20) @(negedge clk);
    rx_exp.push_back({1'b0, 8'hA5});
    n_rx++;
    send_frame(8'hA5, 1'b1, -1);
    wait_rx(n_rx, 2 * BIT_CLKS);
    check("rx_byte_held", 32'(rx_byte), 32'hA5);
    check("rx_idle_after", 32'(is_receiving), 32'd0);

    // break: 20 bit times low
    repeat (20) @(negedge clk);
    rx_exp.push_back({1'b1, 8'h00});
    n_rx++;
    @(negedge clk);
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("break_busy", 32'(is_receiving), 32'd1);
    wait_rx(n_rx, 10);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("break_release", 32'(is_receiving), 32'd0);
    check("break_rx_byte_kept", 32'(rx_byte), 32'hA5);

    // glitch: 300 clocks low
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", 32'(is_receiving), 32'd1);
    repeat (290) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_abort", 32'(is_receiving), 32'd0);
    check("glitch_no_pulse", 32'(rx_events), 32'(n_rx));

    // full duplex
    tx_exp.push_back(8'h3C);
    rx_exp.push_back({1'b0, 8'hC3});
    n_rx++;
    do_transmit(8'h3C);
    send_frame(8'hC3, 1'b1, -1);
    wait_rx(n_rx, 2 * BIT_CLKS);
    wait_tx(2, 2 * BIT_CLKS);
    check("duplex_rx_byte", 32'(rx_byte), 32'hC3);

`ifdef UART_RX_FILTER_EN
    // one-clock glitch right at the data bit 0 mid-sample
    repeat (20) @(negedge clk);
    rx_exp.push_back({1'b0, 8'h5A});
    n_rx++;
    send_frame(8'h5A, 1'b1, BIT_CLKS + HALF_BIT);
    wait_rx(n_rx, 2 * BIT_CLKS);
    check("filter_rx_byte", 32'(rx_byte), 32'h5A);
`endif

    // reset mid-frame in both directions
    repeat (20) @(negedge clk);
    do_transmit(8'h00);
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    check("pre_rst_tx_busy", 32'(is_transmitting), 32'd1);
    check("pre_rst_rx_busy", 32'(is_receiving), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_busy", 32'(is_transmitting), 32'd0);
    check("mid_rst_rx_busy", 32'(is_receiving), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("mid_rst_no_rx_pulse", 32'(rx_events), 32'(n_rx));
    check("mid_rst_no_tx_frame", 32'(tx_frames), 32'd2);

    check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
